// File: rtl/channel_rr_arbiter.sv
// Round-robin channel arbiter for 8 IDs with bounded tenure,
// registered grant outputs and a one-cycle turnaround gap.
module channel_rr_arbiter #(
  parameter int N_CH     = 8,
  parameter int ID_W     = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  output logic            grant_valid,
  output logic [N_CH-1:0] grant_onehot,
  output logic [ID_W-1:0] grant_id,
  output logic            preempt,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  localparam int HL = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [7:0] HOLD_LIM = 8'(HL);
  localparam logic [N_CH-1:0] ONE = N_CH'(1);

  state_t          state;
  state_t          state_n;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_n;
  logic [7:0]      hold_cnt;
  logic [7:0]      hold_n;
  logic [ID_W-1:0] id_n;
  logic            pre_n;
  logic            gv_n;
  logic [N_CH-1:0] oh_n;
  logic            busy_n;

  logic [ID_W-1:0] win;
  logic [ID_W-1:0] idx;
  logic            win_ok;
  logic            rel;
  logic            others;
  logic            hold_hit;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    win    = ptr;
    idx    = ptr;
    win_ok = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = ptr + k[ID_W-1:0];
      if (req[idx]) begin
        win    = idx;
        win_ok = 1'b1;
      end
    end
  end

  assign rel      = !req[grant_id];
  assign others   = |(req & ~grant_onehot);
  assign hold_hit = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      hold_cnt     <= '0;
      grant_valid  <= 1'b0;
      grant_onehot <= '0;
      grant_id     <= '0;
      preempt      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      ptr          <= ptr_n;
      hold_cnt     <= hold_n;
      grant_valid  <= gv_n;
      grant_onehot <= oh_n;
      grant_id     <= id_n;
      preempt      <= pre_n;
      busy         <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    id_n    = grant_id;
    pre_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_ok) begin
          state_n = GRANT;
          id_n    = win;
          hold_n  = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          state_n = GAP;
          ptr_n   = grant_id + 1'b1;
        end else if (hold_hit && others) begin
          state_n = GAP;
          ptr_n   = grant_id + 1'b1;
          pre_n   = 1'b1;
        end else if (hold_cnt != 8'hFF) begin
          hold_n = hold_cnt + 8'd1;
        end
      end
      GAP: begin
        if (win_ok) begin
          state_n = GRANT;
          id_n    = win;
          hold_n  = '0;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    gv_n   = (state_n == GRANT);
    oh_n   = gv_n ? (ONE << id_n) : '0;
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_channel_rr_arbiter.sv
// Scoreboard bench for channel_rr_arbiter: two instances
// (tenure limit 4 and pre-emption disabled) against one model.
module tb_channel_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;

  logic       gv4, pre4, busy4;
  logic [7:0] oh4;
  logic [2:0] id4;
  logic       gv0, pre0, busy0;
  logic [7:0] oh0;
  logic [2:0] id0;

  always #5 clk = ~clk;

  channel_rr_arbiter #(.N_CH(8), .ID_W(3), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .grant_valid(gv4), .grant_onehot(oh4), .grant_id(id4),
    .preempt(pre4), .busy(busy4)
  );

  channel_rr_arbiter #(.N_CH(8), .ID_W(3), .MAX_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .req(req),
    .grant_valid(gv0), .grant_onehot(oh0), .grant_id(id0),
    .preempt(pre0), .busy(busy0)
  );

  // mode: 0 idle, 1 granted, 2 turnaround; ten = cycles granted so far
  typedef struct {
    int mode;
    int ptr;
    int owner;
    int ten;
    bit pre;
  } mdl_t;

  typedef struct {
    bit         gv;
    logic [7:0] oh;
    logic [2:0] id;
    bit         pre;
    bit         busy;
  } exp_t;

  exp_t q4[$];
  exp_t q0[$];
  exp_t e4, e0;
  mdl_t m4, m0;
  int n_chk = 0;
  int n_fail = 0;

  function automatic int winner(int p, logic [7:0] q);
    for (int k = 0; k < 8; k++) begin
      if (q[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  function automatic mdl_t step(mdl_t s, logic r, logic [7:0] q, int m);
    mdl_t n;
    logic [7:0] one;
    one = 8'h01;
    n = s;
    n.pre = 1'b0;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    case (s.mode)
      0: begin
        if (q != 0) begin
          n.mode = 1;
          n.owner = winner(s.ptr, q);
          n.ten = 1;
        end
      end
      1: begin
        if (!q[s.owner]) begin
          n.mode = 2;
          n.ptr = (s.owner + 1) % 8;
        end else if (m != 0 && s.ten >= m && (q & ~(one << s.owner)) != 0) begin
          n.mode = 2;
          n.ptr = (s.owner + 1) % 8;
          n.pre = 1'b1;
        end else begin
          n.ten = s.ten + 1;
        end
      end
      default: begin
        if (q != 0) begin
          n.mode = 1;
          n.owner = winner(n.ptr, q);
          n.ten = 1;
        end else begin
          n.mode = 0;
        end
      end
    endcase
    return n;
  endfunction

  function automatic exp_t expo(mdl_t s);
    exp_t e;
    logic [7:0] one;
    one = 8'h01;
    e.gv = (s.mode == 1);
    e.oh = e.gv ? (one << s.owner) : 8'h00;
    e.id = 3'(s.owner);
    e.pre = s.pre;
    e.busy = (s.mode != 0);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      chk("h4.grant_valid", 32'(gv4), 32'(e4.gv));
      chk("h4.grant_onehot", 32'(oh4), 32'(e4.oh));
      chk("h4.grant_id", 32'(id4), 32'(e4.id));
      chk("h4.preempt", 32'(pre4), 32'(e4.pre));
      chk("h4.busy", 32'(busy4), 32'(e4.busy));
    end
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      chk("h0.grant_valid", 32'(gv0), 32'(e0.gv));
      chk("h0.grant_onehot", 32'(oh0), 32'(e0.oh));
      chk("h0.grant_id", 32'(id0), 32'(e0.id));
      chk("h0.preempt", 32'(pre0), 32'(e0.pre));
      chk("h0.busy", 32'(busy0), 32'(e0.busy));
    end
  end

  task automatic cyc(input logic r, input logic [7:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    m4 = step(m4, r, q, 4);
    q4.push_back(expo(m4));
    m0 = step(m0, r, q, 0);
    q0.push_back(expo(m0));
    #1;
  endtask

  logic [7:0] rq;

  initial begin
    m4 = '{default: 0};
    m0 = '{default: 0};
    rst = 1'b1;
    req = 8'h00;
    // reset and idle
    repeat (2) cyc(1'b1, 8'h00);
    repeat (10) cyc(1'b0, 8'h00);
    // single request on ID7, pointer wraps to 0
    repeat (3) cyc(1'b0, 8'h80);
    repeat (3) cyc(1'b0, 8'h00);
    // two competitors, tenure-driven rotation
    cyc(1'b1, 8'h00);
    repeat (24) cyc(1'b0, 8'h14);
    // release-driven rotation
    cyc(1'b1, 8'h00);
    repeat (2) cyc(1'b0, 8'h0A);
    repeat (5) cyc(1'b0, 8'h08);
    repeat (4) cyc(1'b0, 8'h02);
    // lone requester
    repeat (40) cyc(1'b0, 8'h08);
    // ID5 granted then reset mid-grant, then everyone requests
    repeat (2) cyc(1'b0, 8'h20);
    repeat (3) cyc(1'b0, 8'h20);
    cyc(1'b1, 8'h20);
    repeat (30) cyc(1'b0, 8'hFF);
    // randomized traffic with occasional reset
    rq = 8'h00;
    repeat (400) begin
      if ($urandom_range(3) == 0) rq = 8'($urandom) & 8'($urandom);
      cyc($urandom_range(63) == 0, rq);
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drain", 32'(q4.size() + q0.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
